// File: rtl/multi_digit_state_display_if.sv
// rtl/multi_digit_state_display_if.sv - button and 7-seg display signal bundle
interface multi_digit_state_display_if #(
  parameter int STATE_W = 3
);
  logic               BTNL;
  logic               BTNC;
  logic               BTNR;
  logic [STATE_W-1:0] STATE_OUT;
  logic [7:0]         TRANS_COUNT;
  logic [3:0]         SEG_SELECT_OUT;
  logic [7:0]         DEC_OUT;

  // Board / stimulus side: drives buttons, observes the display
  modport master (
    output BTNL, BTNC, BTNR,
    input  STATE_OUT, TRANS_COUNT, SEG_SELECT_OUT, DEC_OUT
  );

  // Display controller side
  modport slave (
    input  BTNL, BTNC, BTNR,
    output STATE_OUT, TRANS_COUNT, SEG_SELECT_OUT, DEC_OUT
  );
endinterface

// File: rtl/multi_digit_state_display.sv
// rtl/multi_digit_state_display.sv - button-stepped N-state index with 4-digit scanned 7-seg display (optional BTN_DEBOUNCE_EN)
module multi_digit_state_display #(
  parameter int NUM_STATES      = 6,
  parameter int STATE_W         = 3,
  parameter int HOME_STATE      = 0,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  multi_digit_state_display_if.slave   bus
);

  localparam logic [STATE_W-1:0] HOME_S = STATE_W'(HOME_STATE);
  localparam logic [STATE_W-1:0] LAST_S = STATE_W'(NUM_STATES - 1);
  localparam logic [7:0]         HOME_V = 8'(HOME_STATE);
  localparam int                 RW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]      REF_LAST = RW'(REFRESH_DIV - 1);

  if (NUM_STATES < 2 || STATE_W < 1 || STATE_W > 8 || NUM_STATES > (1 << STATE_W) ||
      HOME_STATE < 0 || HOME_STATE >= NUM_STATES || REFRESH_DIV < 2 || DEBOUNCE_CYCLES < 1)
  begin : g_bad_params
    $error("multi_digit_state_display: parameter out of range");
  end

  // Active-low 7-segment glyphs {g,f,e,d,c,b,a} for 0-F
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Button bit order everywhere: [0]=L, [1]=C, [2]=R
  logic [2:0] btn_raw;
  logic [2:0] sync1, sync2;
  logic [1:0] sync_vld;
  logic [2:0] level, level_d, armed, press;

  assign btn_raw = {bus.BTNR, bus.BTNC, bus.BTNL};

  // Two-flop synchroniser; sync_vld marks when sync2 carries real post-reset samples
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [2:0][CNT_W-1:0] deb_cnt;
  logic [2:0]            deb_level;

  // Level rises after DEBOUNCE_CYCLES consecutive high samples, drops on the first low one
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      deb_cnt   <= '0;
      deb_level <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!sync2[i]) begin
          deb_cnt[i]   <= '0;
          deb_level[i] <= 1'b0;
        end else if (!deb_level[i]) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
          if (deb_cnt[i] + 1'b1 == CNT_DONE) deb_level[i] <= 1'b1;
        end
      end
    end
  end

  assign level = deb_level;
`else
  assign level = sync2;
`endif

  // Edge detect; a button must be seen released after reset before it may fire again
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      level_d <= '0;
      armed   <= '0;
    end else begin
      level_d <= level;
      armed   <= armed | ({3{sync_vld[1]}} & ~sync2);
    end
  end

  assign press = level & ~level_d & armed;

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         count_q, count_d;

  // State register: current index and accepted-transition count
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= HOME_S;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: C beats L/R, L+R cancels, ends wrap or saturate
  always_comb begin
    state_d = state_q;
    if (press[1]) begin
      state_d = HOME_S;
    end else if (press[0] && press[2]) begin
      state_d = state_q;
    end else if (press[0]) begin
      if (state_q == '0) state_d = (WRAP != 0) ? LAST_S : state_q;
      else               state_d = state_q - 1'b1;
    end else if (press[2]) begin
      if (state_q == LAST_S) state_d = (WRAP != 0) ? '0 : state_q;
      else                   state_d = state_q + 1'b1;
    end
    count_d = count_q + 8'(state_d != state_q);
  end

  // Outputs of the state machine
  always_comb begin
    bus.STATE_OUT   = state_q;
    bus.TRANS_COUNT = count_q;
  end

  logic [7:0]    state_ext;
  logic [1:0]    digit_q, digit_n;
  logic [RW-1:0] refresh_q;
  logic [3:0]    nib_n;
  logic [3:0]    seg_q, seg_n;
  logic [7:0]    dec_q, dec_n;

  // Next slot's anode and segment pattern, taken from the values registered now
  always_comb begin
    state_ext                = '0;
    state_ext[STATE_W-1:0]   = state_q;
    digit_n                  = digit_q + 2'd1;
    case (digit_n)
      2'd0:    nib_n = state_ext[3:0];
      2'd1:    nib_n = state_ext[7:4];
      2'd2:    nib_n = count_q[3:0];
      default: nib_n = count_q[7:4];
    endcase
    dec_n = {(digit_n != 2'd2), glyph(nib_n)};
    seg_n = ~(4'b0001 << digit_n);
  end

  // Scan timer: anode and segments reload together at each slot boundary
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      refresh_q <= '0;
      digit_q   <= '0;
      seg_q     <= 4'b1110;
      dec_q     <= {1'b1, glyph(HOME_V[3:0])};
    end else if (refresh_q == REF_LAST) begin
      refresh_q <= '0;
      digit_q   <= digit_n;
      seg_q     <= seg_n;
      dec_q     <= dec_n;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign bus.SEG_SELECT_OUT = seg_q;
  assign bus.DEC_OUT        = dec_q;

endmodule

// File: tb/tb_multi_digit_state_display.sv
// tb/tb_multi_digit_state_display.sv - scoreboard bench for multi_digit_state_display (WRAP=1 and WRAP=0 side by side)
module tb_multi_digit_state_display;
  localparam int NS   = 6;
  localparam int SW   = 3;
  localparam int HOME = 0;
  localparam int RD   = 4;
  localparam int DEB  = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int LAT      = DEB + 2;
  localparam int MIN_HOLD = DEB;
  localparam int MAX_HOLD = DEB + 3;
`else
  localparam int LAT      = 2;
  localparam int MIN_HOLD = 1;
  localparam int MAX_HOLD = 4;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  multi_digit_state_display_if #(.STATE_W(SW)) bus_w ();
  multi_digit_state_display_if #(.STATE_W(SW)) bus_s ();

  multi_digit_state_display #(
    .NUM_STATES(NS), .STATE_W(SW), .HOME_STATE(HOME), .WRAP(1),
    .DEBOUNCE_CYCLES(DEB), .REFRESH_DIV(RD)
  ) dut_w (.CLK(clk), .RESET(resetn), .bus(bus_w));

  multi_digit_state_display #(
    .NUM_STATES(NS), .STATE_W(SW), .HOME_STATE(HOME), .WRAP(0),
    .DEBOUNCE_CYCLES(DEB), .REFRESH_DIV(RD)
  ) dut_s (.CLK(clk), .RESET(resetn), .bus(bus_s));

  typedef struct {
    int due;
    int sw;
    int cw;
    int ss;
    int cs;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  bit   rst_seen = 1'b0;
  bit   started = 1'b0;

  logic [6:0] glyph_t [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Stimulus-side model
  int m_sw = HOME, m_cw = 0, m_ss = HOME, m_cs = 0;

  function automatic int next_state(int s, bit l, bit c, bit r, bit wrap);
    if (c)           return HOME;
    if (l && r)      return s;
    if (l)           return (s == 0) ? (wrap ? NS - 1 : 0) : s - 1;
    if (r)           return (s == NS - 1) ? (wrap ? 0 : s) : s + 1;
    return s;
  endfunction

  function automatic logic [7:0] dec_for(int d, int s, int c);
    int nib;
    case (d)
      0:       nib = s % 16;
      1:       nib = (s / 16) % 16;
      2:       nib = c % 16;
      default: nib = (c / 16) % 16;
    endcase
    return {(d != 2), glyph_t[nib]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, edge_n, got, exp);
    end
  endtask

  task automatic set_btn(input bit l, input bit c, input bit r);
    bus_w.BTNL = l; bus_w.BTNC = c; bus_w.BTNR = r;
    bus_s.BTNL = l; bus_s.BTNC = c; bus_s.BTNR = r;
  endtask

  task automatic press(input bit l, input bit c, input bit r, input int hold, input int gap);
    int k;
    int nw;
    int ns;
    @(negedge clk);
    set_btn(l, c, r);
    k = edge_n + 1;
    if (hold >= MIN_HOLD) begin
      nw = next_state(m_sw, l, c, r, 1'b1);
      ns = next_state(m_ss, l, c, r, 1'b0);
      if (nw != m_sw) m_cw = (m_cw + 1) % 256;
      if (ns != m_ss) m_cs = (m_cs + 1) % 256;
      m_sw = nw;
      m_ss = ns;
      sb.push_back('{k + LAT, m_sw, m_cw, m_ss, m_cs});
    end
    repeat (hold) @(negedge clk);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_sw = HOME; m_cw = 0; m_ss = HOME; m_cs = 0;
  endtask

  // Record what the DUTs saw at each rising edge
  always @(posedge clk) begin
    edge_n++;
    rst_seen = resetn;
  end

  // Monitor: retire due expectations, track the scan, compare every cycle
  int   r = 0;
  exp_t cur, prv, e;
  logic [7:0] exp_dec_w, exp_dec_s;
  always @(negedge clk) begin
    if (!rst_seen) begin
      started = 1'b1;
      r = 0;
      cur = '{0, HOME, 0, HOME, 0};
      sb.delete();
      exp_dec_w = dec_for(0, HOME, 0) | 8'h80;
      exp_dec_s = exp_dec_w;
    end else if (started) begin
      prv = cur;
      r++;
      while (sb.size() > 0 && sb[0].due <= edge_n) begin
        e = sb.pop_front();
        cur = e;
      end
      if (r % RD == 0) begin
        exp_dec_w = dec_for((r / RD) % 4, prv.sw, prv.cw);
        exp_dec_s = dec_for((r / RD) % 4, prv.ss, prv.cs);
      end
    end
    if (started) begin
      check("state_wrap", 32'(bus_w.STATE_OUT), cur.sw);
      check("count_wrap", 32'(bus_w.TRANS_COUNT), cur.cw);
      check("state_sat", 32'(bus_s.STATE_OUT), cur.ss);
      check("count_sat", 32'(bus_s.TRANS_COUNT), cur.cs);
      check("seg_wrap", 32'(bus_w.SEG_SELECT_OUT), 32'(4'hF & ~(4'h1 << ((r / RD) % 4))));
      check("seg_sat", 32'(bus_s.SEG_SELECT_OUT), 32'(4'hF & ~(4'h1 << ((r / RD) % 4))));
      check("dec_wrap", 32'(bus_w.DEC_OUT), 32'(exp_dec_w));
      check("dec_sat", 32'(bus_s.DEC_OUT), 32'(exp_dec_s));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d got=timeout exp=finish", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    set_btn(1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    press(1'b0, 1'b0, 1'b1, MIN_HOLD, 4);
    press(1'b0, 1'b0, 1'b1, 20, 4);
    press(1'b1, 1'b0, 1'b0, MIN_HOLD, 4);
    press(1'b1, 1'b0, 1'b0, MIN_HOLD, 4);
    press(1'b1, 1'b1, 1'b0, MIN_HOLD, 4);
    press(1'b1, 1'b0, 1'b1, MIN_HOLD, 4);
    repeat (3) press(1'b0, 1'b0, 1'b1, MIN_HOLD, 4);
    press(1'b0, 1'b1, 1'b1, MIN_HOLD, 4);
    press(1'b0, 1'b0, 1'b1, MIN_HOLD - 1 > 0 ? MIN_HOLD - 1 : MIN_HOLD, 4);

    for (int i = 0; i < 150; i++) begin
      int combo;
      combo = int'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) combo = 4;
      if ($urandom_range(0, 3) == 0) combo = 1;
      press(combo[0], combo[1], combo[2], int'($urandom_range(1, MAX_HOLD)), int'($urandom_range(3, 6)));
    end
    repeat (LAT + 4) @(negedge clk);

    set_btn(1'b0, 1'b0, 1'b1);
    do_reset();
    repeat (10) @(negedge clk);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    press(1'b0, 1'b0, 1'b1, MIN_HOLD, 4);
    press(1'b1, 1'b0, 1'b0, MIN_HOLD, 4);
    press(1'b1, 1'b0, 1'b0, MIN_HOLD, 4);

    repeat (LAT + 10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
